// File: rtl/clock_pkg.sv
// Shared encodings and BCD helpers for the clock/alarm core.
package clock_pkg;
   localparam logic [1:0] MODE_RUN       = 2'b00;
   localparam logic [1:0] MODE_SET_TIME  = 2'b01;
   localparam logic [1:0] MODE_SET_ALARM = 2'b10;

   localparam logic [1:0] FLD_HR = 2'd2;
   localparam logic [1:0] FLD_MN = 2'd1;
   localparam logic [1:0] FLD_SD = 2'd0;

   localparam logic [7:0] BCD_MAX_HR = 8'h23;
   localparam logic [7:0] BCD_MAX_MS = 8'h59;

   typedef enum logic [1:0] {
      ST_RUN       = 2'b00,
      ST_SET_TIME  = 2'b01,
      ST_SET_ALARM = 2'b10
   } state_t;

   // Returns {pm, hour_bcd} for a legal 24h BCD hour.
   function automatic logic [8:0] bcd_to_12h(input logic [7:0] hr);
      logic [7:0] t;
      t = hr - 8'h12;
      if (hr == 8'h00) return {1'b0, 8'h12};
      if (hr < 8'h12)  return {1'b0, hr};
      if (hr == 8'h12) return {1'b1, 8'h12};
      if (t[3:0] > 4'd9) t = t - 8'h06;
      return {1'b1, t};
   endfunction
endpackage

// File: rtl/bcd_field_cnt.sv
// Two-digit BCD counter wrapping at MAX; nxt exposes the value it will load.
module bcd_field_cnt
   import clock_pkg::*;
#(
   parameter logic [7:0] MAX = BCD_MAX_MS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   output logic [7:0] val,
   output logic [7:0] nxt,
   output logic       wrap
);
   logic [7:0] step;

   always_comb begin
      if (val == MAX)
         step = 8'h00;
      else if (val[3:0] == 4'd9)
         step = {val[7:4] + 4'd1, 4'd0};
      else
         step = {val[7:4], val[3:0] + 4'd1};
   end

   assign wrap = inc && (val == MAX);
   assign nxt  = clr ? 8'h00 : (inc ? step : val);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         val <= 8'h00;
      else
         val <= nxt;
   end
endmodule

// File: rtl/clock_alarm_core.sv
// Timekeeping core: prescaler, time/alarm setting FSM, alarm ring and 12/24h view.
module clock_alarm_core
   import clock_pkg::*;
#(
   parameter int CLK_HZ   = 50_000_000,
   parameter int RING_SEC = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  mode,
   input  logic        btn_next,
   input  logic        btn_inc,
   input  logic        h12,
   input  logic        alarm_en,
   input  logic        ring_ack,
   output logic [23:0] tm,
   output logic [1:0]  field,
   output logic        pm,
   output logic        sec_pulse,
   output logic        ring
);
   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int RW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;

   state_t          state, state_nxt;
   logic [PW-1:0]   presc;
   logic [RW-1:0]   ring_cnt;
   logic            tick, set_t, set_a, match;
   logic            sd_inc, mn_inc, hr_inc, ah_inc, am_inc;
   logic            sd_wrap, mn_wrap, hr_wrap, ah_wrap, am_wrap, unused_wrap;
   logic [7:0]      sd, mn, hr, ahr, amn;
   logic [7:0]      sd_nxt, mn_nxt, hr_nxt, ahr_nxt, amn_nxt;
   logic [7:0]      view_hr;
   logic [15:0]     view_lo;
   logic [8:0]      hr12;

   always_comb begin
      case (mode)
         MODE_SET_TIME:  state_nxt = ST_SET_TIME;
         MODE_SET_ALARM: state_nxt = ST_SET_ALARM;
         default:        state_nxt = ST_RUN;
      endcase
   end

   assign set_t = (state == ST_SET_TIME);
   assign set_a = (state == ST_SET_ALARM);
   assign tick  = !set_t && (presc == PW'(CLK_HZ - 1));

   // Carries only ride on ticks, so manual edits never spill into the next field.
   assign sd_inc = tick | (set_t & btn_inc & (field == FLD_SD));
   assign mn_inc = (tick & sd_wrap) | (set_t & btn_inc & (field == FLD_MN));
   assign hr_inc = (tick & mn_wrap) | (set_t & btn_inc & (field == FLD_HR));
   assign ah_inc = set_a & btn_inc & (field == FLD_HR);
   assign am_inc = set_a & btn_inc & (field == FLD_MN);
   assign unused_wrap = ^{hr_wrap, ah_wrap, am_wrap};

   bcd_field_cnt #(.MAX(BCD_MAX_MS)) u_sd  (.clk(clk), .rst(rst), .inc(sd_inc), .clr(1'b0), .val(sd),  .nxt(sd_nxt),  .wrap(sd_wrap));
   bcd_field_cnt #(.MAX(BCD_MAX_MS)) u_mn  (.clk(clk), .rst(rst), .inc(mn_inc), .clr(1'b0), .val(mn),  .nxt(mn_nxt),  .wrap(mn_wrap));
   bcd_field_cnt #(.MAX(BCD_MAX_HR)) u_hr  (.clk(clk), .rst(rst), .inc(hr_inc), .clr(1'b0), .val(hr),  .nxt(hr_nxt),  .wrap(hr_wrap));
   bcd_field_cnt #(.MAX(BCD_MAX_HR)) u_ahr (.clk(clk), .rst(rst), .inc(ah_inc), .clr(1'b0), .val(ahr), .nxt(ahr_nxt), .wrap(ah_wrap));
   bcd_field_cnt #(.MAX(BCD_MAX_MS)) u_amn (.clk(clk), .rst(rst), .inc(am_inc), .clr(1'b0), .val(amn), .nxt(amn_nxt), .wrap(am_wrap));

   // Compare against the post-tick time so ring rises right after the tick.
   assign match = tick && alarm_en && (sd_nxt == 8'h00) && (mn_nxt == amn) && (hr_nxt == ahr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RUN;
         field <= FLD_HR;
      end else begin
         state <= state_nxt;
         if (state_nxt != state && state_nxt != ST_RUN)
            field <= FLD_HR;
         else if (btn_next && set_t)
            field <= (field == FLD_SD) ? FLD_HR : field - 2'd1;
         else if (btn_next && set_a)
            field <= (field == FLD_HR) ? FLD_MN : FLD_HR;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         presc <= '0;
      else if (set_t || tick)
         presc <= '0;
      else
         presc <= presc + PW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ring     <= 1'b0;
         ring_cnt <= '0;
      end else if (ring_ack || !alarm_en) begin
         ring     <= 1'b0;
         ring_cnt <= '0;
      end else if (match) begin
         ring     <= 1'b1;
         ring_cnt <= '0;
      end else if (ring && tick) begin
         if (ring_cnt == RW'(RING_SEC - 1))
            ring <= 1'b0;
         else
            ring_cnt <= ring_cnt + RW'(1);
      end
   end

   always_comb begin
      view_hr = set_a ? ahr : hr;
      view_lo = set_a ? {amn, 8'h00} : {mn, sd};
      hr12    = bcd_to_12h(view_hr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tm        <= '0;
         pm        <= 1'b0;
         sec_pulse <= 1'b0;
      end else begin
         tm        <= {h12 ? hr12[7:0] : view_hr, view_lo};
         pm        <= h12 & hr12[8];
         sec_pulse <= tick;
      end
   end
endmodule
